lsu_axi_master: RTL and testbench
=================================

// Module: lsu_axi_master
// PURPOSE
//  Load/store unit bus master for the RV32I core: turns one core load/store request into a single
//  AXI4-Lite transaction to the data-memory slave. Generates byte strobes, lane-replicated store
//  data, load alignment and sign/zero extension. Rejects misaligned and illegal accesses without
//  touching the bus. One outstanding request at a time; the core stalls while req_ready=0.
// PARAMETERS
//  ADDR_W  12  AXI address width (byte address); the core address is truncated to ADDR_W bits
// PORTS
//  clk          in   1       clock
//  reset        in   1       reset, synchronous, active-low
//  req_valid    in   1       core request valid
//  req_ready    out  1       request accepted when req_valid&&req_ready
//  req_we       in   1       1=store, 0=load
//  req_addr     in   32      byte address
//  req_size     in   2       00=byte, 01=half, 10=word, 11=illegal
//  req_unsigned in   1       load zero-extends (LBU/LHU)
//  req_wdata    in   32      store data, right-aligned
//  resp_valid   out  1       one-cycle completion pulse
//  resp_rdata   out  32      extended load data (0 for stores/errors)
//  resp_err     out  1       misaligned, illegal or slave error
//  awvalid/awready out/in 1; awaddr out ADDR_W; awprot out 3    write address channel
//  wvalid/wready   out/in 1; wdata out 32; wstrb out 4           write data channel
//  bvalid/bready   in/out 1; bresp in 1 (1=OKAY)                 write response channel
//  arvalid/arready out/in 1; araddr out ADDR_W; arprot out 3     read address channel
//  rvalid/rready   in/out 1; rdata in 32; rresp in 1 (1=OKAY)    read data channel
// BEHAVIOUR
//  Reset (reset=0 at posedge): state IDLE; every valid/ready output, resp_rdata, resp_err = 0;
//   req_ready=0 while reset=0. Mid-transaction reset aborts immediately, no resp_valid.
//  FSM: IDLE -> (accept) WR | RD | RESP(err); WR -> WRESP when AW and W both done;
//   WRESP -> RESP on bvalid&&bready; RD -> RDATA on arvalid&&arready; RDATA -> RESP on
//   rvalid&&rready; RESP -> IDLE.
//  req_ready=1 only in IDLE. Accept latches addr/size/unsigned/we/wdata; core inputs ignored after.
//  Illegal: size=11, half with addr[0]=1, word with addr[1:0]!=0 -> RESP next cycle, resp_err=1,
//   no AXI valid ever raised.
//  awaddr/araddr = {addr[ADDR_W-1:2],2'b00}; awprot=arprot=3'b000. Addresses/data stable while valid.
//  Store: wdata byte={4{d[7:0]}}, half={2{d[15:0]}}, word=d. wstrb byte=4'b0001<<addr[1:0],
//   half=4'b0011<<{addr[1],1'b0}, word=4'b1111.
//  WR: awvalid and wvalid rise together the cycle after accept; each drops independently after its
//   own handshake (tracked by aw_done/w_done flags). bready=1 only in WRESP.
//  RD: arvalid held until arready; rready=1 only in RDATA. Load data = rdata >> (8*addr[1:0]),
//   then byte/half sign-extended (req_unsigned=0) or zero-extended; word unmodified.
//  resp_err in RESP = ~bresp (store) / ~rresp (load); resp_rdata captured at R handshake, 0 on
//   store. resp_valid=1 only in RESP, exactly one cycle.
//  Latency, always-ready slave: accept cycle 0, AW+W or AR handshake cycle 1, B or R handshake
//   cycle 2, resp_valid cycle 3, req_ready again cycle 4. Illegal: resp_valid cycle 1.
//  bvalid/rvalid arriving while bready/rready=0 are ignored (not handshakes).
// TESTING
//  T1 reset=0 for 3 cycles with req_valid=1 -> all valids, req_ready, resp_valid 0; reset=1 -> req_ready=1.
//  T2 SB addr 0x0A3 data 0x000000C5 -> awaddr 0x0A0, wdata 0xC5C5C5C5, wstrb 4'b1000, resp_valid cycle 3, err 0.
//  T3 LH addr 0x012, slave rdata 0x80017FFF -> resp_rdata 0xFFFF8001; LHU same -> 0x00008001; LB addr 0x011 -> 0x0000007F.
//  T4 SW with awready low 3 cycles, wready high -> wvalid drops after cycle 1, awvalid/awaddr held, bready rises only after AW handshake.
//  T5 LW addr 0x006 -> no arvalid, resp_valid cycle 1, resp_err=1; store with bresp=0 -> resp_err=1.
//  T6 reset=0 during RDATA -> next cycle all outputs 0, no resp_valid; fresh request then completes normally.

Source files
------------

// File: rtl/lsu_axi_master_if.sv
// AXI4-Lite master/slave channel bundle used between the load/store unit and data memory.
// Responses carry a single OKAY bit (1=OKAY) instead of the full 2-bit encoding.
interface lsu_axi_master_if #(
    parameter int ADDR_W = 12
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic              bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/lsu_axi_master.sv
// RV32I load/store unit bus master: one core request becomes one AXI4-Lite transaction,
// with store lane replication/strobes, load alignment/extension and misalignment rejection.
module lsu_axi_master #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    lsu_axi_master_if.master axi
);
    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, RESP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic        illegal;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    // Request decode: alignment check and store lane placement straight from the core inputs.
    always_comb begin
        illegal  = 1'b0;
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
        case (req_size)
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                illegal  = req_addr[0];
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = 4'b0011 << {req_addr[1], 1'b0};
            end
            2'b10:   illegal = |req_addr[1:0];
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        ld_shift = axi.rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   ld_data = {{24{~uns_q & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = {{16{~uns_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    assign req_ready   = reset && (state_q == IDLE);
    assign axi.awvalid = (state_q == WR) && !aw_done_q;
    assign axi.wvalid  = (state_q == WR) && !w_done_q;
    assign axi.bready  = (state_q == WRESP);
    assign axi.arvalid = (state_q == RD);
    assign axi.rready  = (state_q == RDATA);
    assign axi.awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign axi.araddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign axi.awprot  = 3'b000;
    assign axi.arprot  = 3'b000;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = resp_valid ? rdata_q : 32'h0;
    assign resp_err    = resp_valid & err_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                addr_d    = req_addr[ADDR_W-1:0];
                size_d    = req_size;
                uns_d     = req_unsigned;
                wdata_d   = st_wdata;
                wstrb_d   = st_wstrb;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                rdata_d   = 32'h0;
                err_d     = illegal;
                if (illegal)     state_d = RESP;
                else if (req_we) state_d = WR;
                else             state_d = RD;
            end
            // AW and W complete independently; the B phase waits for both.
            WR: begin
                aw_done_d = aw_done_q | (axi.awvalid & axi.awready);
                w_done_d  = w_done_q | (axi.wvalid & axi.wready);
                if (aw_done_d && w_done_d) state_d = WRESP;
            end
            WRESP: if (axi.bvalid) begin
                err_d   = ~axi.bresp;
                state_d = RESP;
            end
            RD: if (axi.arready) state_d = RDATA;
            RDATA: if (axi.rvalid) begin
                err_d   = ~axi.rresp;
                rdata_d = axi.rresp ? ld_data : 32'h0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: directed vector table, reset/abort sequences, and randomized
// transactions against a timeline/arithmetic reference model with a reactive AXI slave.
module tb_lsu_axi_master;
    localparam int ADDR_W = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    lsu_axi_master_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_axi_master #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .axi(bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] srdata;
        logic        sresp;
        int          aw_w, w_w, ar_w, b_w, r_w;
        logic        e_ill;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [11:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        int          e_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata, input logic [31:0] srdata,
                                 input logic sresp, input int aw_w, input logic ill, input logic err,
                                 input logic [31:0] rdata, input logic [11:0] eaddr,
                                 input logic [31:0] ewdata, input logic [3:0] ewstrb, input int lat);
        vec_t v;
        v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
        v.srdata = srdata; v.sresp = sresp;
        v.aw_w = aw_w; v.w_w = 0; v.ar_w = 0; v.b_w = 0; v.r_w = 0;
        v.e_ill = ill; v.e_err = err; v.e_rdata = rdata; v.e_addr = eaddr;
        v.e_wdata = ewdata; v.e_wstrb = ewstrb; v.e_lat = lat;
        return v;
    endfunction

    // Reference model: expected bus values, load result and completion cycle from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t        r = v;
        int unsigned a = v.addr % 4;
        logic [31:0] sh, val;
        int          aw_hs, w_hs;
        r.e_ill  = (v.size == 3) || (v.size == 1 && (a % 2) != 0) || (v.size == 2 && a != 0);
        r.e_addr = 12'((v.addr % 4096) - a);
        sh = v.srdata >> (8 * a);
        case (v.size)
            2'd0: begin
                r.e_wdata = (v.wdata % 256) * 32'h01010101;
                r.e_wstrb = 4'(1 << a);
                val = sh % 256;
                if (!v.uns && val >= 128) val = val + 32'hFFFFFF00;
            end
            2'd1: begin
                r.e_wdata = (v.wdata % 65536) * 32'h00010001;
                r.e_wstrb = 4'(3 << a);
                val = sh % 65536;
                if (!v.uns && val >= 32768) val = val + 32'hFFFF0000;
            end
            default: begin
                r.e_wdata = v.wdata;
                r.e_wstrb = 4'hF;
                val = sh;
            end
        endcase
        r.e_err   = r.e_ill ? 1'b1 : !v.sresp;
        r.e_rdata = (r.e_ill || v.we || !v.sresp) ? 32'h0 : val;
        aw_hs = 1 + v.aw_w;
        w_hs  = 1 + v.w_w;
        if (r.e_ill)   r.e_lat = 1;
        else if (v.we) r.e_lat = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + v.b_w + 1;
        else           r.e_lat = 1 + v.ar_w + 1 + v.r_w + 1;
        return r;
    endfunction

    task automatic slave_idle();
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int   aw_hs, w_hs, wr_end, b_hs, ar_hs, r_hs, resp_c;
        int   bad_ctl, bad_aw, bad_w, bad_ar;
        bit   done;
        logic ev_aw, ev_w, ev_b, ev_ar, ev_r;
        logic [31:0] got_rdata;
        logic got_err;
        aw_hs = 1 + v.aw_w; w_hs = 1 + v.w_w; wr_end = (aw_hs > w_hs) ? aw_hs : w_hs;
        b_hs = wr_end + 1 + v.b_w; ar_hs = 1 + v.ar_w; r_hs = ar_hs + 1 + v.r_w;
        bad_ctl = 0; bad_aw = 0; bad_w = 0; bad_ar = 0; done = 0; resp_c = -1;
        got_rdata = 32'h0; got_err = 1'b0;
        slave_idle();
        @(negedge clk);
        chk({nm, "/ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
        req_unsigned = v.uns; req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_wdata = $urandom;
        for (int c = 1; c <= 80 && !done; c++) begin
            @(negedge clk);
            ev_aw = !v.e_ill && v.we && c <= aw_hs;
            ev_w  = !v.e_ill && v.we && c <= w_hs;
            ev_b  = !v.e_ill && v.we && c > wr_end && c <= b_hs;
            ev_ar = !v.e_ill && !v.we && c <= ar_hs;
            ev_r  = !v.e_ill && !v.we && c > ar_hs && c <= r_hs;
            if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, req_ready} !==
                {ev_aw, ev_w, ev_b, ev_ar, ev_r, 1'b0}) bad_ctl++;
            if (bus.awvalid && (bus.awaddr !== v.e_addr || bus.awprot !== 3'b0)) bad_aw++;
            if (bus.wvalid && ({bus.wdata, bus.wstrb} !== {v.e_wdata, v.e_wstrb})) bad_w++;
            if (bus.arvalid && (bus.araddr !== v.e_addr || bus.arprot !== 3'b0)) bad_ar++;
            bus.awready = (c >= aw_hs);
            bus.wready  = (c >= w_hs);
            bus.arready = (c >= ar_hs);
            if (bus.bready) begin
                bus.bvalid = (c >= b_hs); bus.bresp = v.sresp;
            end else begin
                bus.bvalid = 1'($urandom); bus.bresp = 1'($urandom);
            end
            if (bus.rready) begin
                bus.rvalid = (c >= r_hs); bus.rdata = v.srdata; bus.rresp = v.sresp;
            end else begin
                bus.rvalid = 1'($urandom); bus.rdata = $urandom; bus.rresp = 1'($urandom);
            end
            if (resp_valid) begin
                resp_c = c; got_rdata = resp_rdata; got_err = resp_err; done = 1;
            end
        end
        chk({nm, "/resp_seen"}, 32'(done), 32'd1);
        chk({nm, "/latency"}, 32'(resp_c), 32'(v.e_lat));
        chk({nm, "/resp_err"}, 32'(got_err), 32'(v.e_err));
        chk({nm, "/resp_rdata"}, got_rdata, v.e_rdata);
        chk({nm, "/ctl_timeline_bad"}, 32'(bad_ctl), 32'd0);
        if (!v.e_ill && v.we) begin
            chk({nm, "/aw_bad"}, 32'(bad_aw), 32'd0);
            chk({nm, "/w_bad"}, 32'(bad_w), 32'd0);
        end
        if (!v.e_ill && !v.we) chk({nm, "/ar_bad"}, 32'(bad_ar), 32'd0);
        slave_idle();
        @(negedge clk);
        chk({nm, "/resp_one_cycle"}, 32'(resp_valid), 32'd0);
        chk({nm, "/ready_again"}, 32'(req_ready), 32'd1);
        if (!done) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
        end
    endtask

    vec_t tbl[14];
    vec_t v;
    bit   seen;

    initial begin
        tbl[0]  = mkv(1, 32'h0A3, 0, 0, 32'hC5, 0, 1, 0, 0, 0, 0, 12'h0A0, 32'hC5C5C5C5, 4'b1000, 3);
        tbl[1]  = mkv(0, 32'h012, 1, 0, 0, 32'h80017FFF, 1, 0, 0, 0, 32'hFFFF8001, 12'h010, 0, 0, 3);
        tbl[2]  = mkv(0, 32'h012, 1, 1, 0, 32'h80017FFF, 1, 0, 0, 0, 32'h00008001, 12'h010, 0, 0, 3);
        tbl[3]  = mkv(0, 32'h011, 0, 0, 0, 32'h80017FFF, 1, 0, 0, 0, 32'h0000007F, 12'h010, 0, 0, 3);
        tbl[4]  = mkv(1, 32'h100, 2, 0, 32'hDEADBEEF, 0, 1, 3, 0, 0, 0, 12'h100, 32'hDEADBEEF, 4'hF, 6);
        tbl[5]  = mkv(0, 32'h006, 2, 0, 0, 32'h11111111, 1, 0, 1, 1, 0, 12'h004, 0, 0, 1);
        tbl[6]  = mkv(1, 32'h002, 1, 0, 32'h1234ABCD, 0, 0, 0, 0, 1, 0, 12'h000, 32'hABCDABCD, 4'b1100, 3);
        tbl[7]  = mkv(1, 32'h001, 1, 0, 32'h55, 0, 1, 0, 1, 1, 0, 12'h000, 0, 0, 1);
        tbl[8]  = mkv(0, 32'h000, 3, 0, 0, 32'h22222222, 1, 0, 1, 1, 0, 12'h000, 0, 0, 1);
        tbl[9]  = mkv(0, 32'h003, 0, 1, 0, 32'hF0000000, 1, 0, 0, 0, 32'h000000F0, 12'h000, 0, 0, 3);
        tbl[10] = mkv(1, 32'hFFFFF004, 2, 0, 32'h01234567, 0, 1, 0, 0, 0, 0, 12'h004, 32'h01234567, 4'hF, 3);
        tbl[11] = mkv(0, 32'h008, 2, 0, 0, 32'h12345678, 0, 0, 0, 1, 0, 12'h008, 0, 0, 3);
        tbl[12] = mkv(1, 32'h0A1, 0, 0, 32'hABCDEF7E, 0, 1, 0, 0, 0, 0, 12'h0A0, 32'h7E7E7E7E, 4'b0010, 3);
        tbl[13] = mkv(0, 32'h013, 0, 0, 0, 32'h85000000, 1, 0, 0, 0, 32'hFFFFFF85, 12'h010, 0, 0, 3);

        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = 32'h0;
        slave_idle();
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_outputs", 32'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                                      req_ready, resp_valid, resp_err, |resp_rdata}), 32'd0);
        end
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_release_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting in the read-data phase must abort without a response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h020; req_size = 2'b10; req_unsigned = 1'b0;
        bus.arready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_arvalid", 32'(bus.arvalid), 32'd1);
        @(negedge clk);
        chk("abort_in_rdata", 32'(bus.rready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 32'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                                  req_ready, resp_valid, resp_err, |resp_rdata}), 32'd0);
        reset = 1'b1;
        bus.rvalid = 1'b1; bus.rdata = 32'hFFFFFFFF; bus.rresp = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || bus.rready) seen = 1;
        end
        chk("abort_no_resp", 32'(seen), 32'd0);
        slave_idle();
        run_txn(mkv(0, 32'h020, 2, 0, 0, 32'h13579BDF, 1, 0, 0, 0, 32'h13579BDF, 12'h020, 0, 0, 3),
                "abort_fresh");

        for (int i = 0; i < 150; i++) begin
            v.we = 1'($urandom); v.size = 2'($urandom); v.addr = $urandom;
            if (($urandom % 4) != 0 && v.size != 2'd3) v.addr = v.addr & ~((32'd1 << v.size) - 1);
            v.uns = 1'($urandom); v.wdata = $urandom; v.srdata = $urandom;
            v.sresp = (($urandom % 6) != 0);
            v.aw_w = $urandom % 4; v.w_w = $urandom % 4; v.ar_w = $urandom % 4;
            v.b_w = $urandom % 4; v.r_w = $urandom % 4;
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
